// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan sequencer.
// Holds the scan FSM state encoding and the channel-mask walker.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CONVERT,
        STORE,
        NEXT
    } state_t;

    // Next set bit above idx within the lowest n bits of mask.
    // When none remains, wrap=1 and the lowest set bit is returned.
    function automatic logic [3:0] next_set(
        input  logic [15:0] mask,
        input  int          idx,
        input  int          n,
        output logic        wrap
    );
        logic [3:0] r_ch;
        logic       found;
        r_ch  = '0;
        found = 1'b0;
        wrap  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!found && i > idx && i < n && mask[i]) begin
                r_ch  = 4'(i);
                found = 1'b1;
                wrap  = 1'b0;
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (!found && i < n && mask[i]) begin
                r_ch  = 4'(i);
                found = 1'b1;
            end
        end
        return r_ch;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter shared by mux settle and convert timeout.
// Terminal count is flagged while the count sits at zero.
module cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load has priority over counting down.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans masked analog mux channels through an external ADC.
// Settle, discard, capture and timeout are handled per channel.
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 8,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DISCARD        = 0,
    parameter int TIMEOUT_CYCLES = 2000000,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    continuous,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    algo_sar_cfg,
    input  logic                    adc_ready,
    input  logic [WIDTH-1:0]        adc_raw,
    output logic [CH_W-1:0]         mux_sel,
    output logic                    adc_enable,
    output logic                    adc_algo_sar,
    output logic                    result_valid,
    output logic [CH_W-1:0]         result_ch,
    output logic [WIDTH-1:0]        result_data,
    output logic [NUM_CH*WIDTH-1:0] results_flat,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clear
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                             SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DISC_W  = $clog2(DISCARD + 2);

    state_t                  r_state;
    logic [NUM_CH-1:0]       r_mask;
    logic                    r_algo;
    logic [CH_W-1:0]         r_mux;
    logic [DISC_W-1:0]       r_disc;
    logic [CH_W-1:0]         r_rch;
    logic [WIDTH-1:0]        r_rdata;
    logic [NUM_CH*WIDTH-1:0] r_flat;
    logic                    r_terr;

    logic [15:0]             w_mask16;
    int                      w_idx;
    logic                    w_wrap;
    logic [CH_W-1:0]         w_nxt_ch;
    logic                    w_load;
    logic [CNT_W-1:0]        w_val;
    logic                    w_en;
    logic                    w_tc;
    logic                    w_capture;
    logic                    w_timeout;

    cycle_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_val),
        .i_en    (w_en),
        .o_tc    (w_tc)
    );

    // Channel walker: lowest live bit in IDLE, next shadow bit otherwise.
    always_comb begin
        w_mask16 = (r_state == IDLE) ? 16'(ch_mask) : 16'(r_mask);
        w_idx    = (r_state == IDLE) ? NUM_CH - 1 : int'(r_mux);
        w_wrap   = 1'b0;
        w_nxt_ch = CH_W'(next_set(w_mask16, w_idx, NUM_CH, w_wrap));
    end

    // Counter control: settle on channel entry, timeout on convert entry.
    always_comb begin
        w_load = 1'b0;
        w_val  = CNT_W'(SETTLE_CYCLES - 1);
        w_en   = 1'b0;
        unique case (r_state)
            IDLE:    w_load = 1'b1;
            SELECT: begin
                if (w_tc) begin
                    w_load = 1'b1;
                    w_val  = CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    w_en = 1'b1;
                end
            end
            CONVERT: w_en   = ~w_tc;
            STORE:   w_load = 1'b0;
            NEXT:    w_load = 1'b1;
            default: w_load = 1'b0;
        endcase
    end

    assign w_capture = (r_state == CONVERT) && adc_ready &&
                       (r_disc == DISC_W'(DISCARD));
    assign w_timeout = (r_state == CONVERT) && !w_capture && w_tc;

    // Scan FSM with shadowed config and captured results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_algo  <= 1'b0;
            r_mux   <= '0;
            r_disc  <= '0;
            r_rch   <= '0;
            r_rdata <= '0;
            r_flat  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start && |ch_mask) begin
                        r_mask  <= ch_mask;
                        r_algo  <= algo_sar_cfg;
                        r_mux   <= w_nxt_ch;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    r_disc <= '0;
                    if (w_tc)
                        r_state <= CONVERT;
                end
                CONVERT: begin
                    if (w_capture) begin
                        r_rch   <= r_mux;
                        r_rdata <= adc_raw;
                        for (int i = 0; i < NUM_CH; i++)
                            if (r_mux == CH_W'(i))
                                r_flat[i*WIDTH +: WIDTH] <= adc_raw;
                        r_state <= STORE;
                    end else if (w_timeout) begin
                        r_state <= NEXT;
                    end else if (adc_ready) begin
                        r_disc <= r_disc + 1'b1;
                    end
                end
                STORE: r_state <= NEXT;
                NEXT: begin
                    if (!w_wrap || continuous) begin
                        r_mux   <= w_nxt_ch;
                        r_state <= SELECT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky timeout flag; a new timeout beats a clear.
    always_ff @(posedge clk) begin
        if (reset)
            r_terr <= 1'b0;
        else if (w_timeout)
            r_terr <= 1'b1;
        else if (err_clear)
            r_terr <= 1'b0;
    end

    assign mux_sel      = r_mux;
    assign busy         = (r_state != IDLE);
    assign adc_enable   = (r_state == CONVERT);
    assign adc_algo_sar = busy & r_algo;
    assign result_valid = (r_state == STORE);
    assign result_ch    = r_rch;
    assign result_data  = r_rdata;
    assign results_flat = r_flat;
    assign timeout_err  = r_terr;

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of analog mux channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 8: ADC code width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1000: mux settle time in clocks (>=1).
REQ-004 SHALL have parameter DISCARD, default 0: ready pulses discarded per channel before capture.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 2000000: max clocks in CONVERT per channel (>=2).
REQ-006 SHALL have port clk  in  1  system clock.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  begin a scan when idle.
REQ-009 SHALL have port continuous  in  1  repeat scans while high.
REQ-010 SHALL have port ch_mask  in  NUM_CH  channels to scan.
REQ-011 SHALL have port algo_sar_cfg  in  1  ADC algorithm for the scan (0 ramp, 1 SAR).
REQ-012 SHALL have port adc_ready  in  1  ADC conversion strobe.
REQ-013 SHALL have port adc_raw  in  WIDTH  ADC captured code.
REQ-014 SHALL have port mux_sel  out  CH_W=$clog2(NUM_CH)  external analog mux select.
REQ-015 SHALL have port adc_enable  out  1  ADC enable.
REQ-016 SHALL have port adc_algo_sar  out  1  ADC algorithm select.
REQ-017 SHALL have port result_valid  out  1  one-clock new-result strobe.
REQ-018 SHALL have port result_ch  out  CH_W  channel of current result.
REQ-019 SHALL have port result_data  out  WIDTH  captured code.
REQ-020 SHALL have port results_flat  out  NUM_CH*WIDTH  latest code per channel, ch0 in LSBs.
REQ-021 SHALL have port busy  out  1  high whenever not IDLE.
REQ-022 SHALL have port timeout_err  out  1  sticky timeout flag.
REQ-023 SHALL have port err_clear  in  1  clears timeout_err.

Function
REQ-024 SHALL implement FSM states IDLE, SELECT, CONVERT, STORE, NEXT.
REQ-025 IDLE: start=1 and ch_mask!=0 latches ch_mask, algo_sar_cfg into shadow registers, loads lowest set channel into mux_sel, enters SELECT next cycle; start with ch_mask=0 is ignored.
REQ-026 start while busy SHALL be ignored; config changes mid-scan SHALL take effect only at next scan start.
REQ-027 SELECT: count SETTLE_CYCLES clocks with adc_enable=0, then enter CONVERT.
REQ-028 CONVERT: adc_enable=1, adc_algo_sar=shadow algo; count adc_ready pulses; pulse number DISCARD+1 enters STORE with adc_raw registered.
REQ-029 adc_enable SHALL be 0 in every state except CONVERT; adc_algo_sar SHALL hold shadow algo while busy.
REQ-030 CONVERT exceeding TIMEOUT_CYCLES clocks without capture SHALL set timeout_err and enter NEXT with no result stored.
REQ-031 STORE: result_valid=1 for exactly one clock with result_ch=mux_sel, result_data=captured code; results_flat slice updated same clock.
REQ-032 NEXT: select next higher set shadow-mask bit, enter SELECT; after the highest set bit, wrap to lowest set bit if continuous=1 (sampled in NEXT), else enter IDLE.
REQ-033 Single-channel mask in continuous mode SHALL reconvert that channel each pass, including SELECT settle.
REQ-034 adc_ready outside CONVERT SHALL be ignored.
REQ-035 err_clear SHALL clear timeout_err unless a timeout sets it the same cycle (set wins).
REQ-036 result_ch, result_data SHALL hold last values between strobes.

Reset
REQ-037 reset SHALL force IDLE; mux_sel, result_ch, result_data, results_flat, counters, shadow registers 0; adc_enable, adc_algo_sar, result_valid, busy, timeout_err 0.
REQ-038 reset mid-scan SHALL abort immediately with no result_valid emitted.

Structure
REQ-039 Shared package adc_pkg SHALL hold the FSM state enum and a function returning next set mask bit after a given index (with wrap flag).
REQ-040 One sub-module, cycle_counter (load, enable, terminal-count output), SHALL serve settle and timeout counting.

Verification
REQ-041 mask=4'b1010, SETTLE=4, DISCARD=0, one start: ready 5 clocks into CONVERT with raw=0x3C on ch1, 0x81 on ch3 -> two strobes (ch1,0x3C),(ch3,0x81), results_flat=0x8100_3C00, then IDLE.
REQ-042 continuous=1, mask=4'b0001: strobes repeat on ch0; drop continuous -> IDLE after current result.
REQ-043 DISCARD=2: three ready pulses (0x10,0x20,0x30) -> single strobe with 0x30.
REQ-044 No adc_ready, TIMEOUT_CYCLES=50 -> timeout_err=1 after 50 CONVERT clocks, next channel proceeds; err_clear -> 0.
REQ-045 reset asserted in CONVERT -> next cycle all outputs at reset values, no strobe; start with mask=0 -> busy stays 0.
